// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a common-anode/cathode multi-digit 7-segment
//   display. A shadow copy of {num, dp, blank} is captured on load. A
//   prescaler produces one tick every CLK_DIV cycles. Each tick advances the
//   scanned digit and leaves one all-dark output cycle as an anti-ghost gap.
//
//   Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to darken leading
//   zero digits. Digit 0 is never darkened, and decimal points are still shown.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset
//   num    : 4*DIGITS hex nibbles, nibble k drives digit k (digit 0 = LSD)
//   dp     : per-digit decimal point request
//   blank  : per-digit force-dark
//   load   : capture strobe for num/dp/blank
//   disp   : segments, disp[0]=a .. disp[6]=g (registered, polarity per ACTIVE_LOW)
//   dp_out : decimal point segment (registered)
//   an     : digit enables, one-hot or none (registered)
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [6:0]            disp,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an
);

    localparam int   CW  = $clog2(CLK_DIV);
    localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic [4*DIGITS-1:0]   sh_num;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;

    logic [3:0]            nib;
    logic [DIGITS-1:0]     lz;
    logic                  dark;
    logic [6:0]            disp_nxt;
    logic                  dp_nxt;
    logic [DIGITS-1:0]     an_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Prescaler, digit index and shadow register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            sh_num   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            if (load) begin
                sh_num   <= num;
                sh_dp    <= dp;
                sh_blank <= blank;
            end
        end
    end

    // lz[k]: nibbles k..DIGITS-1 are all zero and k > 0
    always_comb begin
        lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            logic acc;
            acc = 1'b1;
            for (int k = DIGITS - 1; k > 0; k--) begin
                acc   = acc & (sh_num[4*k +: 4] == 4'h0);
                lz[k] = acc;
            end
        end
`endif
    end

    // Next output values, active-high; the tick cycle produces the dark gap
    always_comb begin
        nib      = sh_num[4*idx +: 4];
        dark     = sh_blank[idx] | lz[idx];
        an_nxt   = tick ? '0 : (DIGITS'(1) << idx);
        disp_nxt = (tick || dark) ? 7'h00 : seg_decode(nib);
        dp_nxt   = !tick && sh_dp[idx] && !sh_blank[idx];
    end

    // Output register with polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            an     <= {DIGITS{POL}};
            disp   <= {7{POL}};
            dp_out <= POL;
        end else begin
            an     <= an_nxt ^ {DIGITS{POL}};
            disp   <= disp_nxt ^ {7{POL}};
            dp_out <= dp_nxt ^ POL;
        end
    end

endmodule
